// File: rtl/snax_csr_tracking_translator_if.sv
// SNAX accelerator port <-> simplified CSR req/rsp port bundle.
// Signal names keep the translator's historical port names so existing
// hookups can be mapped one-to-one. The package carries the default SNAX
// request/response structs and the CSR instruction match patterns.

package snax_csr_tracking_translator_pkg;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] data_op;
    logic [31:0] data_arga;
    logic [31:0] data_argb;
  } acc_req_t;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] data;
    logic        error;
  } acc_rsp_t;

  // Read-type CSR instructions (rd receives the old value, no plain write)
  localparam logic [31:0] CSRRS  = 32'b?????????????????010?????1110011;
  localparam logic [31:0] CSRRC  = 32'b?????????????????011?????1110011;
  localparam logic [31:0] CSRRSI = 32'b?????????????????110?????1110011;
  localparam logic [31:0] CSRRCI = 32'b?????????????????111?????1110011;

endpackage

interface snax_csr_tracking_translator_if #(
  parameter type         acc_req_t = snax_csr_tracking_translator_pkg::acc_req_t,
  parameter type         acc_rsp_t = snax_csr_tracking_translator_pkg::acc_rsp_t,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
);
  // SNAX side
  logic                 snax_qvalid_i;
  logic                 snax_qready_o;
  acc_req_t             snax_req_i;
  acc_rsp_t             snax_resp_o;
  logic                 snax_pvalid_o;
  logic                 snax_pready_i;
  // CSR manager side
  logic [DataWidth-1:0] io_csr_req_bits_data_i;
  logic [AddrWidth-1:0] io_csr_req_bits_addr_i;
  logic                 io_csr_req_bits_write_i;
  logic                 io_csr_req_valid_i;
  logic                 io_csr_req_ready_o;
  logic                 io_csr_rsp_ready_i;
  logic                 io_csr_rsp_valid_o;
  logic [DataWidth-1:0] io_csr_rsp_bits_data_o;

  // Translator view
  modport slave (
    input  snax_qvalid_i, snax_req_i, snax_pready_i,
           io_csr_req_ready_o, io_csr_rsp_valid_o, io_csr_rsp_bits_data_o,
    output snax_qready_o, snax_resp_o, snax_pvalid_o,
           io_csr_req_bits_data_i, io_csr_req_bits_addr_i, io_csr_req_bits_write_i,
           io_csr_req_valid_i, io_csr_rsp_ready_i
  );

  // Environment view (Snitch port plus CSR manager)
  modport master (
    output snax_qvalid_i, snax_req_i, snax_pready_i,
           io_csr_req_ready_o, io_csr_rsp_valid_o, io_csr_rsp_bits_data_o,
    input  snax_qready_o, snax_resp_o, snax_pvalid_o,
           io_csr_req_bits_data_i, io_csr_req_bits_addr_i, io_csr_req_bits_write_i,
           io_csr_req_valid_i, io_csr_rsp_ready_i
  );

endinterface

// File: rtl/snax_csr_tracking_translator.sv
// SNAX CSR request/response translator with in-order tag tracking.
// Requests go straight through combinationally; a small tag FIFO remembers
// {id, err} for every accepted request so each response carries its id.
// Optional feature: define SNAX_CSR_TRANSLATOR_RANGE_CHECK_EN to answer
// out-of-range CSR addresses locally with error = 1 instead of forwarding.

module snax_csr_tracking_translator #(
  parameter type         acc_req_t      = snax_csr_tracking_translator_pkg::acc_req_t,
  parameter type         acc_rsp_t      = snax_csr_tracking_translator_pkg::acc_rsp_t,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned IdWidth        = 5,
  parameter logic [31:0] CsrAddrOffset  = 32'h3c0,
  parameter int unsigned NumCsr         = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input logic                           clk_i,
  input logic                           rst_ni,
  snax_csr_tracking_translator_if.slave bus
);

  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  if (MaxOutstanding < 1) begin : g_depth_check
    $error("MaxOutstanding must be at least 1");
  end
  if (NumCsr < 1) begin : g_numcsr_check
    $error("NumCsr must be at least 1");
  end

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               err;
  } tag_t;

  acc_req_t            req;
  acc_rsp_t            rsp;
  tag_t                mem [MaxOutstanding];
  tag_t                head;
  logic [PtrWidth-1:0] wptr;
  logic [PtrWidth-1:0] rptr;
  logic [CntWidth-1:0] cnt;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                loc_err;
  logic                is_read;

  assign req = bus.snax_req_i;

  localparam int unsigned ArgWidth = $bits(req.data_argb);

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // ---------------------------------------------------------------- request
  logic [ArgWidth-1:0] addr_diff;

  assign addr_diff = req.data_argb - ArgWidth'(CsrAddrOffset);

`ifdef SNAX_CSR_TRANSLATOR_RANGE_CHECK_EN
  // One extra bit so CsrAddrOffset + NumCsr cannot wrap around
  typedef logic [ArgWidth:0] ext_t;
  assign loc_err = (ext_t'(req.data_argb) <  ext_t'(CsrAddrOffset)) |
                   (ext_t'(req.data_argb) >= ext_t'(CsrAddrOffset) + ext_t'(NumCsr));
`else
  assign loc_err = 1'b0;
`endif

  // Classify the instruction: set/clear variants only read back
  always_comb begin
    is_read = 1'b0;
    casez (req.data_op)
      snax_csr_tracking_translator_pkg::CSRRS,
      snax_csr_tracking_translator_pkg::CSRRSI,
      snax_csr_tracking_translator_pkg::CSRRC,
      snax_csr_tracking_translator_pkg::CSRRCI: is_read = 1'b1;
      default:                                  is_read = 1'b0;
    endcase
  end

  assign bus.io_csr_req_bits_data_i  = req.data_arga[DataWidth-1:0];
  assign bus.io_csr_req_bits_addr_i  = AddrWidth'(addr_diff);
  assign bus.io_csr_req_bits_write_i = rst_ni & bus.snax_qvalid_i & ~is_read;
  assign bus.io_csr_req_valid_i      = bus.snax_qvalid_i & ~full & ~loc_err;
  // Locally answered requests only need a free tag slot, not the downstream
  assign bus.snax_qready_o           = ~full & (bus.io_csr_req_ready_o | loc_err);

  assign push = bus.snax_qvalid_i & bus.snax_qready_o;

  // --------------------------------------------------------------- response
  assign full  = (cnt == CntWidth'(MaxOutstanding));
  assign empty = (cnt == '0);
  assign head  = mem[rptr];

  assign bus.snax_pvalid_o      = ~empty & (head.err | bus.io_csr_rsp_valid_o);
  assign bus.io_csr_rsp_ready_i = ~empty & ~head.err & bus.snax_pready_i;

  assign pop = bus.snax_pvalid_o & bus.snax_pready_i;

  // Assemble the SNAX response from the head tag and downstream data
  always_comb begin
    rsp       = '0;
    rsp.id    = head.id;
    rsp.error = head.err;
    if (!head.err) begin
      rsp.data[DataWidth-1:0] = bus.io_csr_rsp_bits_data_o;
    end
  end

  assign bus.snax_resp_o = rsp;

  // ---------------------------------------------------------------- storage
  // Tag slots carry no reset; only the pointers define what is valid
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr] <= '{id: req.id[IdWidth-1:0], err: loc_err};
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together keep cnt
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= next_ptr(wptr);
      if (pop)  rptr <= next_ptr(rptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CntWidth'(1);
        2'b01:   cnt <= cnt - CntWidth'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A downstream response with nothing outstanding cannot be matched to a request
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(bus.io_csr_rsp_valid_o && empty))
    else $error("csr response valid with no outstanding request");

endmodule

// File: tb/tb_snax_csr_tracking_translator.sv
// Bench for snax_csr_tracking_translator: table of single requests plus
// hand sequences for full/backpressure/reset; responses checked by a
// scoreboard queue filled at request acceptance.

module tb_snax_csr_tracking_translator;

`ifdef SNAX_CSR_TRANSLATOR_RANGE_CHECK_EN
  localparam bit RangeCheck = 1'b1;
`else
  localparam bit RangeCheck = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  snax_csr_tracking_translator_if bus ();

  snax_csr_tracking_translator #(
    .DataWidth      (32),
    .AddrWidth      (32),
    .IdWidth        (5),
    .CsrAddrOffset  (32'h3c0),
    .NumCsr         (64),
    .MaxOutstanding (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  id;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] op;
    logic [31:0] argb;
    logic [31:0] arga;
    logic [4:0]  id;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_write;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] down_q[$];
  exp_t        e;
  logic        down_en;
  logic [31:0] cur_rdata;
  logic        cur_err;
  int          tests;
  int          fails;
  vec_t        vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic model_err(input logic [31:0] argb);
    return RangeCheck && ((argb < 32'h3c0) || (argb >= 32'h400));
  endfunction

  function automatic logic [31:0] mk_csr(input logic [2:0] f3);
    return {12'h123, 5'd3, f3, 5'd9, 7'h73};
  endfunction

  // Scoreboard: record at acceptance, compare at SNAX response handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      down_q.delete();
    end else begin
      if (bus.snax_pvalid_o && bus.snax_pready_i) begin
        chk("rsp_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_id",    bus.snax_resp_o.id,    e.id);
          chk("rsp_data",  bus.snax_resp_o.data,  e.data);
          chk("rsp_error", bus.snax_resp_o.error, e.err);
        end
      end
      if (bus.io_csr_rsp_valid_o && bus.io_csr_rsp_ready_i) void'(down_q.pop_front());
      if (bus.snax_qvalid_i && bus.snax_qready_o) begin
        exp_q.push_back('{data: cur_err ? 32'h0 : cur_rdata, id: bus.snax_req_i.id, err: cur_err});
        chk("req_forwarded", bus.io_csr_req_valid_i & bus.io_csr_req_ready_o, !cur_err);
        if (bus.io_csr_req_valid_i && bus.io_csr_req_ready_o) down_q.push_back(cur_rdata);
      end
    end
  end

  // Downstream CSR manager: answers forwarded requests in order when enabled
  initial begin
    bus.io_csr_rsp_valid_o     = 1'b0;
    bus.io_csr_rsp_bits_data_o = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.io_csr_rsp_valid_o = down_en && rst_n && (down_q.size() > 0);
      if (down_q.size() > 0) bus.io_csr_rsp_bits_data_o = down_q[0];
      else                   bus.io_csr_rsp_bits_data_o = '0;
    end
  end

  task automatic drive_req(input logic [31:0] op, input logic [31:0] argb,
                           input logic [31:0] arga, input logic [4:0] id,
                           input logic [31:0] rdata);
    bus.snax_qvalid_i = 1'b1;
    bus.snax_req_i    = '{id: id, data_op: op, data_arga: arga, data_argb: argb};
    cur_rdata         = rdata;
    cur_err           = model_err(argb);
  endtask

  task automatic issue(input logic [31:0] op, input logic [31:0] argb,
                       input logic [31:0] arga, input logic [4:0] id,
                       input logic [31:0] rdata, input bit check_req,
                       input logic [31:0] exp_addr, input logic exp_write);
    bit ok = 1'b0;
    drive_req(op, argb, arga, id, rdata);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.snax_qready_o) begin
        ok = 1'b1;
        if (check_req) begin
          chk("req_addr",  bus.io_csr_req_bits_addr_i,  exp_addr);
          chk("req_write", bus.io_csr_req_bits_write_i, exp_write);
          chk("req_data",  bus.io_csr_req_bits_data_i,  arga);
          chk("req_valid", bus.io_csr_req_valid_i,      !model_err(argb));
        end
      end
      @(posedge clk);
      #1;
    end
    bus.snax_qvalid_i = 1'b0;
    chk("req_accepted", ok, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{mk_csr(3'b010), 32'h3c5, 32'h0,        5'd3,  32'hcafe,      32'h5,        1'b0};
    vecs[1] = '{mk_csr(3'b001), 32'h3c0, 32'h12345678, 5'd1,  32'h0,         32'h0,        1'b1};
    vecs[2] = '{mk_csr(3'b110), 32'h3d0, 32'h0,        5'd2,  32'h1111,      32'h10,       1'b0};
    vecs[3] = '{mk_csr(3'b011), 32'h3ff, 32'ha5,       5'd4,  32'hdeadbeef,  32'h3f,       1'b0};
    vecs[4] = '{mk_csr(3'b111), 32'h3c1, 32'h1f,       5'd5,  32'h1,         32'h1,        1'b0};
    vecs[5] = '{mk_csr(3'b101), 32'h3c2, 32'h7,        5'd31, 32'h2,         32'h2,        1'b1};
    vecs[6] = '{mk_csr(3'b001), 32'h3bf, 32'hffffffff, 5'd2,  32'h55,        32'hffffffff, 1'b1};
    vecs[7] = '{mk_csr(3'b001), 32'h400, 32'h0,        5'd8,  32'h66,        32'h40,       1'b1};
    vecs[8] = '{32'h00002003,   32'h3c4, 32'h9,        5'd9,  32'h77,        32'h4,        1'b1};

    // Reset state with a write request presented
    rst_n                  = 1'b0;
    down_en                = 1'b1;
    cur_rdata              = '0;
    cur_err                = 1'b0;
    bus.snax_pready_i      = 1'b1;
    bus.io_csr_req_ready_o = 1'b1;
    drive_req(mk_csr(3'b001), 32'h3c0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    chk("rst_qready",    bus.snax_qready_o,           1);
    chk("rst_req_valid", bus.io_csr_req_valid_i,      1);
    chk("rst_write",     bus.io_csr_req_bits_write_i, 0);
    chk("rst_pvalid",    bus.snax_pvalid_o,           0);
    chk("rst_rsp_ready", bus.io_csr_rsp_ready_i,      0);
    bus.io_csr_req_ready_o = 1'b0;
    #1;
    chk("rst_qready_nordy", bus.snax_qready_o, 0);
    @(posedge clk);
    #1;
    bus.snax_qvalid_i      = 1'b0;
    bus.io_csr_req_ready_o = 1'b1;
    rst_n                  = 1'b1;
    @(posedge clk);
    #1;

    // Table of isolated requests (nine of them also wraps the pointers twice)
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].argb, vecs[i].arga, vecs[i].id, vecs[i].rdata,
            1'b1, vecs[i].exp_addr, vecs[i].exp_write);
      drain();
    end

    // Four back-to-back writes fill the FIFO; a fifth is held off
    down_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      issue(mk_csr(3'b001), 32'h3c0 + 32'(i), 32'(i), 5'(i), 32'h100 + 32'(i), 1'b0, 32'h0, 1'b0);
    end
    drive_req(mk_csr(3'b001), 32'h3c8, 32'h5, 5'd5, 32'h105);
    @(negedge clk);
    chk("full_qready",    bus.snax_qready_o,      0);
    chk("full_req_valid", bus.io_csr_req_valid_i, 0);
    @(posedge clk);
    #1;
    down_en = 1'b1;
    @(negedge clk);
    chk("full_pop_pvalid",  bus.snax_pvalid_o,  1);
    chk("full_pop_no_push", bus.snax_qready_o,  0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("qready_after_pop", bus.snax_qready_o, 1);
    @(posedge clk);
    #1;
    bus.snax_qvalid_i = 1'b0;
    drain();

    // Response backpressure: held response must stay stable
    bus.snax_pready_i = 1'b0;
    issue(mk_csr(3'b010), 32'h3c7, 32'h0, 5'd10, 32'hbeef, 1'b1, 32'h7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_pvalid",    bus.snax_pvalid_o,      1);
      chk("bp_rsp_ready", bus.io_csr_rsp_ready_i, 0);
      chk("bp_id",        bus.snax_resp_o.id,     10);
      chk("bp_data",      bus.snax_resp_o.data,   32'hbeef);
      @(posedge clk);
      #1;
    end
    bus.snax_pready_i = 1'b1;
    drain();

    // Reset with two requests outstanding
    down_en = 1'b0;
    issue(mk_csr(3'b001), 32'h3c0, 32'h1, 5'd11, 32'hb1, 1'b0, 32'h0, 1'b0);
    issue(mk_csr(3'b001), 32'h3c1, 32'h2, 5'd12, 32'hb2, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("pre_rst_pvalid", bus.snax_pvalid_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_pvalid",    bus.snax_pvalid_o,      0);
    chk("mid_rst_rsp_ready", bus.io_csr_rsp_ready_i, 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    down_en = 1'b1;
    @(negedge clk);
    chk("post_rst_pvalid", bus.snax_pvalid_o, 0);
    @(posedge clk);
    #1;
    issue(mk_csr(3'b010), 32'h3c3, 32'h0, 5'd7, 32'h77, 1'b1, 32'h3, 1'b0);
    drain();

    // Out-of-range request followed by a valid one; responses stay in order
    issue(mk_csr(3'b001), 32'h3bf, 32'h0, 5'd2, 32'h11, 1'b1, 32'hffffffff, 1'b1);
    issue(mk_csr(3'b010), 32'h3c1, 32'h0, 5'd6, 32'h66, 1'b1, 32'h1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
